// File: rtl/number_entry_pkg.sv
// Shared sizing constants, FSM state encoding and the hex-to-segment table
// used by the number entry block.
package number_entry_pkg;

   localparam int NUM_BYTES = 32;
   localparam int BYTE_W    = 8;
   localparam int NUM_W     = NUM_BYTES * BYTE_W;
   localparam int IDX_W     = $clog2(NUM_BYTES + 1);

   typedef enum logic {
      ST_ENTER = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Segment order is {g,f,e,d,c,b,a}, active-high.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] seg;
      seg = '0;
      case (hex)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = '0;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex2digit_hex.sv
// Single hex digit to 7-segment decoder; INVERT=1 drives active-low segments.
module hex2digit_hex #(
   parameter bit INVERT = 1'b0
) (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   import number_entry_pkg::*;

   logic [6:0] seg_raw;

   always_comb begin
      seg_raw = hex_to_seg(hex);
      seg     = INVERT ? ~seg_raw : seg_raw;
   end

endmodule

// File: rtl/number_entry.sv
// Byte-by-byte entry of a wide number from board switches, with the current
// entry index shown on two 7-segment digits.
module number_entry #(
   parameter int NUM_BYTES = number_entry_pkg::NUM_BYTES,
   parameter int BYTE_W    = number_entry_pkg::BYTE_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [BYTE_W-1:0]             sw,
   input  logic                          btn_flg_store,
   input  logic                          btn_flg_clear,
   output logic [NUM_BYTES*BYTE_W-1:0]   number,
   output logic                          number_valid,
   output logic                          full,
   output logic [BYTE_W-1:0]             leds,
   output logic [13:0]                   digs
);
   import number_entry_pkg::*;

   localparam int CNT_W = $clog2(NUM_BYTES + 1);
   localparam int SEL_W = $clog2(NUM_BYTES);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_BYTES - 1);
   localparam logic [7:0]       FULL_IDX8 = 8'(NUM_BYTES);

   state_t            state;
   logic [CNT_W-1:0]  idx;
   logic [BYTE_W-1:0] bytes_q [NUM_BYTES];

   logic [7:0]        idx8;
   logic [3:0]        hi_nib;
   logic [3:0]        lo_nib;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_ENTER;
         idx          <= '0;
         leds         <= '0;
         number_valid <= 1'b0;
         full         <= 1'b0;
         for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            bytes_q[i] <= '0;
         end
      end else begin
         number_valid <= 1'b0;
         // Clear takes priority over a coincident store.
         if (btn_flg_clear) begin
            state <= ST_ENTER;
            idx   <= '0;
            leds  <= '0;
            full  <= 1'b0;
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
               bytes_q[i] <= '0;
            end
         end else if (btn_flg_store && state == ST_ENTER) begin
            bytes_q[idx[SEL_W-1:0]] <= sw;
            leds                    <= sw;
            idx                     <= idx + CNT_W'(1);
            if (idx == LAST_IDX) begin
               state        <= ST_FULL;
               full         <= 1'b1;
               number_valid <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_BYTES; g++) begin : g_pack
      assign number[g*BYTE_W +: BYTE_W] = bytes_q[g];
   end

   always_comb begin
      idx8   = 8'(idx);
      lo_nib = idx8[3:0];
      hi_nib = (state == ST_FULL) ? FULL_IDX8[7:4] : idx8[7:4];
   end

   hex2digit_hex #(
      .INVERT(1'b1)
   ) u_dig_hi (
      .hex(hi_nib),
      .seg(digs[13:7])
   );

   hex2digit_hex #(
      .INVERT(1'b1)
   ) u_dig_lo (
      .hex(lo_nib),
      .seg(digs[6:0])
   );

endmodule

// File: tb/tb_number_entry.sv
// Self-checking bench for number_entry: directed scenarios plus random
// store/clear traffic compared against a behavioural byte-array model.
module tb_number_entry;

   logic         clk;
   logic         reset;
   logic [7:0]   sw;
   logic         btn_flg_store;
   logic         btn_flg_clear;
   logic [255:0] number;
   logic         number_valid;
   logic         full;
   logic [7:0]   leds;
   logic [13:0]  digs;

   int total;
   int bad;

   logic [7:0] m_bytes [32];
   int         m_idx;
   bit         m_full;
   bit         m_valid;
   logic [7:0] m_leds;
   logic [6:0] seg_tab [16];

   number_entry #(
      .NUM_BYTES(32),
      .BYTE_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sw(sw),
      .btn_flg_store(btn_flg_store),
      .btn_flg_clear(btn_flg_clear),
      .number(number),
      .number_valid(number_valid),
      .full(full),
      .leds(leds),
      .digs(digs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_bytes[i] = 8'h00;
      m_idx   = 0;
      m_full  = 1'b0;
      m_valid = 1'b0;
      m_leds  = 8'h00;
   endtask

   task automatic check_all(input string where);
      logic [255:0] exp_num;
      logic [13:0]  exp_digs;
      exp_num = '0;
      for (int i = 0; i < 32; i++) exp_num = exp_num | (256'(m_bytes[i]) << (8 * i));
      exp_digs = {~seg_tab[m_idx / 16], ~seg_tab[m_idx % 16]};
      chk({where, ".number"}, number, exp_num);
      chk({where, ".leds"}, 256'(leds), 256'(m_leds));
      chk({where, ".valid"}, 256'(number_valid), 256'(m_valid));
      chk({where, ".full"}, 256'(full), 256'(m_full));
      chk({where, ".digs"}, 256'(digs), 256'(exp_digs));
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, check.
   task automatic step(input string where, input logic st, input logic cl, input logic [7:0] v);
      btn_flg_store = st;
      btn_flg_clear = cl;
      sw            = v;
      @(posedge clk);
      if (cl) begin
         model_clear();
      end else if (st && !m_full) begin
         m_bytes[m_idx] = v;
         m_leds         = v;
         m_idx          = m_idx + 1;
         m_valid        = (m_idx == 32);
         m_full         = (m_idx == 32);
      end else begin
         m_valid = 1'b0;
      end
      #1;
      btn_flg_store = 1'b0;
      btn_flg_clear = 1'b0;
      check_all(where);
   endtask

   initial begin
      logic [255:0] snap_num;
      logic [7:0]   snap_leds;
      logic [13:0]  snap_digs;
      int           r;
      total = 0;
      bad   = 0;
      seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
      seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
      seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
      seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;

      reset         = 1'b1;
      sw            = 8'h00;
      btn_flg_store = 1'b0;
      btn_flg_clear = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      check_all("reset");
      reset = 1'b0;
      @(negedge clk);
      check_all("post_reset");

      // Single store after reset lands in byte 0.
      step("first_store", 1'b1, 1'b0, 8'hA5);
      chk("first_store.byte0", 256'(number[7:0]), 256'(8'hA5));
      chk("first_store.digs01", 256'(digs), 256'({~seg_tab[0], ~seg_tab[1]}));

      // Full fill with i+1.
      step("fill_clear", 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 32; i++) step("fill", 1'b1, 1'b0, 8'(i + 1));
      for (int i = 0; i < 32; i++) chk("fill.byte", 256'(number[8*i +: 8]), 256'(i + 1));
      chk("fill.digs20", 256'(digs), 256'({~seg_tab[2], ~seg_tab[0]}));
      step("fill_after", 1'b0, 1'b0, 8'h00);

      // Stores ignored while full.
      snap_num  = number;
      snap_leds = leds;
      snap_digs = digs;
      step("full_store", 1'b1, 1'b0, 8'hFF);
      chk("full_store.num_hold", number, snap_num);
      chk("full_store.leds_hold", 256'(leds), 256'(snap_leds));
      chk("full_store.digs_hold", 256'(digs), 256'(snap_digs));
      step("full_store2", 1'b1, 1'b0, 8'hFF);

      // Store and clear together: clear wins.
      step("sc_clear", 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 5; i++) step("sc_store", 1'b1, 1'b0, 8'($urandom));
      step("sc_both", 1'b1, 1'b1, 8'h77);
      chk("sc_both.zero", number, 256'(0));

      // Asynchronous reset mid-cycle after 10 stores.
      for (int i = 0; i < 10; i++) step("ar_store", 1'b1, 1'b0, 8'($urandom));
      #3;
      reset = 1'b1;
      #1;
      model_clear();
      check_all("async_reset");
      #1;
      reset = 1'b0;
      step("ar_first", 1'b1, 1'b0, 8'h5A);
      chk("ar_first.byte0", 256'(number[7:0]), 256'(8'h5A));

      // From full, clear then one store.
      for (int i = 0; i < 31; i++) step("rf_store", 1'b1, 1'b0, 8'($urandom));
      chk("rf.full", 256'(full), 256'(1));
      step("rf_clear", 1'b0, 1'b1, 8'h00);
      step("rf_store3c", 1'b1, 1'b0, 8'h3C);
      chk("rf.byte0", 256'(number[7:0]), 256'(8'h3C));

      // Random traffic.
      step("rnd_clear", 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         step("rnd", (r < 70) || (r >= 98), (r >= 96), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/number_entry.md
NUMBER_ENTRY -- requirements
Module: number_entry

Interface
REQ-001 Parameter NUM_BYTES, default 32, number of bytes in the entered number.
REQ-002 Parameter BYTE_W, default 8, width of one entered byte and of sw/leds.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sw  input  8  byte value to store, from board switches.
REQ-006 btn_flg_store  input  1  one-cycle pulse from the existing falling-edge button handler; store sw at the current index.
REQ-007 btn_flg_clear  input  1  one-cycle pulse; discard the entry and restart at index 0.
REQ-008 number  output  256  assembled number, registered; byte i is number[8i+7:8i].
REQ-009 number_valid  output  1  one-cycle pulse when the last byte is stored.
REQ-010 full  output  1  high while all NUM_BYTES bytes are entered.
REQ-011 leds  output  8  last stored byte, registered.
REQ-012 digs  output  14  two active-low 7-segment digits of the 6-bit index; [13:7] high nibble, [6:0] low nibble.

Function
REQ-013 Two-state FSM, ENTER and FULL, with a 6-bit index register idx (range 0..32).
REQ-014 In ENTER, a store pulse writes sw into number byte idx and leds, then increments idx, all in the same cycle.
REQ-015 Store at idx 31 additionally moves the FSM to FULL, sets idx to 32 and asserts number_valid for exactly the next cycle.
REQ-016 In FULL, store pulses are ignored: number, leds and idx are unchanged and number_valid stays low.
REQ-017 full is high exactly while the FSM is in FULL.
REQ-018 A clear pulse in either state zeroes number and leds, sets idx to 0 and moves the FSM to ENTER on the next edge.
REQ-019 When store and clear pulse in the same cycle, clear wins and no byte is written.
REQ-020 Bytes not yet stored read as zero.
REQ-021 digs displays idx as two hex digits: 00..1F while entering, 20 in FULL.
REQ-022 digs is purely combinational from idx, with no added latency.
REQ-023 A level held on btn_flg_store stores once per cycle; edge detection is the caller's job.
REQ-024 Byte order matches the display path, so byte i shows on the leds when the show index is i.

Reset
REQ-025 Asserting reset immediately, without waiting for clk, forces ENTER, idx=0, number=0, leds=0, number_valid=0 and full=0.
REQ-026 Reset during entry discards all bytes already stored; there is no partial retention.
REQ-027 After reset deasserts, the first store pulse writes byte 0.

Structure
REQ-028 A shared package holds NUM_BYTES, BYTE_W, NUM_W (=256), IDX_W (=6) and the FSM state encoding.
REQ-029 The two digit decoders reuse the existing hex2digit_hex module with INVERT=1.
REQ-030 The high-digit instance gets {3'b0, idx[4]} in ENTER and 4'h2 in FULL.
REQ-031 The byte-write decode and the FSM stay inside number_entry, with no further sub-modules.

Verification
REQ-032 Reset, then store sw=8'hA5 once -> number[7:0]=A5, rest 0, leds=A5, digs shows "01", full=0.
REQ-033 32 stores with sw=i+1 -> number byte i = i+1 for all i, number_valid high exactly one cycle after the 32nd store, full=1, digs shows "20".
REQ-034 In FULL, store sw=8'hFF -> number, leds and digs unchanged, no number_valid pulse.
REQ-035 After 5 stores, apply store and clear in the same cycle -> number=0, leds=0, idx=0, digs shows "00".
REQ-036 Assert reset mid-cycle after 10 stores -> outputs zero before the next clk edge; the next store writes byte 0.
REQ-037 After reaching FULL, clear then one store of 8'h3C -> number[7:0]=3C, full=0, digs shows "01".
